edge_event_arbiter: RTL and testbench

Multi-channel dual-edge event scheduler. Each of `NUM_CH` synchronous inputs is watched for rising and falling edges; every detected edge becomes a pending event. Pending events are granted round-robin onto a single valid/ready event port. The block sits between per-pin edge sources and the one downstream consumer (interrupt logger or event FIFO) that shares them.

---
 rtl/edge_event_pkg.sv | 16 +
 rtl/dual_edge_channel.sv | 54 +++++
 rtl/edge_event_arbiter.sv | 107 ++++++++++
 tb/tb_edge_event_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/edge_event_pkg.sv
// Shared types for the dual-edge event arbiter: output FSM state and the presented event record.
package edge_event_pkg;

  localparam int unsigned MaxChW = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'b01,
    StPresent = 2'b10
  } arb_state_t;

  typedef struct packed {
    logic [MaxChW-1:0] ch;
    logic              rise;
  } edge_event_t;

endpackage

// File: rtl/dual_edge_channel.sv
// One input channel: edge detect, single-entry pending event and sticky overflow flag.
module dual_edge_channel (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  input  logic grant_i,
  input  logic clear_overflow_i,
  output logic pend_o,
  output logic pend_rise_o,
  output logic overflow_o
);

  logic prev_q, prev_d;
  logic pend_q, pend_d;
  logic pend_rise_q, pend_rise_d;
  logic overflow_q, overflow_d;
  logic edge_det;

  always_comb begin
    edge_det    = in_i != prev_q;
    prev_d      = in_i;
    pend_d      = pend_q && !grant_i;
    pend_rise_d = pend_rise_q;
    overflow_d  = overflow_q && !clear_overflow_i;
    if (edge_det) begin
      // A grant this cycle frees the slot, so the new edge can take it.
      if (!pend_q || grant_i) begin
        pend_d      = 1'b1;
        pend_rise_d = in_i;
      end else begin
        overflow_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_rise_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      pend_q      <= pend_d;
      pend_rise_q <= pend_rise_d;
      overflow_q  <= overflow_d;
    end
  end

  assign pend_o      = pend_q;
  assign pend_rise_o = pend_rise_q;
  assign overflow_o  = overflow_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel dual-edge event scheduler: per-channel pending edges granted round-robin
// onto a single registered valid/ready event port.
module edge_event_arbiter
  import edge_event_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] in,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [CH_W-1:0]   ev_ch,
  output logic              ev_rise,
  output logic [NUM_CH-1:0] overflow,
  input  logic              clear_overflow
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] pend_rise;
  logic [NUM_CH-1:0] grant;

  arb_state_t  state_q, state_d;
  edge_event_t ev_q, ev_d;
  logic [CH_W-1:0] rr_q, rr_d;
  logic [CH_W-1:0] sel;
  logic            found;
  logic            do_grant;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign grant[c] = do_grant && (sel == CH_W'(c));

    dual_edge_channel u_ch (
      .clk_i            (clk),
      .rst_ni           (reset_n),
      .in_i             (in[c]),
      .grant_i          (grant[c]),
      .clear_overflow_i (clear_overflow),
      .pend_o           (pend[c]),
      .pend_rise_o      (pend_rise[c]),
      .overflow_o       (overflow[c])
    );
  end

  // First pending channel at or after rr, wrapping at NUM_CH-1.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      int unsigned idx;
      idx = 32'(rr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && pend[CH_W'(idx)]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ev_d     = ev_q;
    rr_d     = rr_q;
    do_grant = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          do_grant = 1'b1;
          state_d  = StPresent;
        end
      end
      StPresent: begin
        if (ev_ready) begin
          if (found) do_grant = 1'b1;
          else       state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (do_grant) begin
      ev_d.ch   = MaxChW'(sel);
      ev_d.rise = pend_rise[sel];
      rr_d      = (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + CH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ev_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      ev_q    <= ev_d;
      rr_q    <= rr_d;
    end
  end

  logic unused_ch;
  assign unused_ch = ^ev_q.ch;

  assign ev_valid = (state_q == StPresent);
  assign ev_ch    = ev_q.ch[CH_W-1:0];
  assign ev_rise  = ev_q.rise;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with a cycle-level event model and literal spot checks.
module tb_edge_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [N-1:0] din = '0;
  logic         ev_ready = 1'b1;
  logic         clear_overflow = 1'b0;
  logic         ev_valid;
  logic [1:0]   ev_ch;
  logic         ev_rise;
  logic [N-1:0] overflow;

  int  n_cmp = 0;
  int  n_err = 0;
  bit  chk_en = 1'b0;

  edge_event_arbiter #(.NUM_CH(N)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in             (din),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_ch          (ev_ch),
    .ev_rise        (ev_rise),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Event model: each channel holds at most one pending edge; the output slot is refilled
  // from the pending set (round-robin from m_rr) whenever it is empty or being taken.
  logic [N-1:0] m_prev, m_pend, m_rise, m_ovf;
  bit           m_valid;
  int           m_ch, m_rr, g;
  bit           m_erise;

  initial begin
    m_prev = '0; m_pend = '0; m_rise = '0; m_ovf = '0;
    m_valid = 0; m_ch = 0; m_erise = 0; m_rr = 0;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_prev = '0; m_pend = '0; m_rise = '0; m_ovf = '0;
      m_valid = 0; m_ch = 0; m_erise = 0; m_rr = 0;
    end else begin
      if (!m_valid || ev_ready) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
        if (g >= 0) begin
          m_valid = 1; m_ch = g; m_erise = m_rise[g];
          m_pend[g] = 1'b0;
          m_rr = (g + 1) % N;
        end else begin
          m_valid = 0;
        end
      end
      if (clear_overflow) m_ovf = '0;
      for (int c = 0; c < N; c++) begin
        if (din[c] != m_prev[c]) begin
          if (m_pend[c]) m_ovf[c] = 1'b1;
          else begin
            m_pend[c] = 1'b1;
            m_rise[c] = din[c];
          end
          m_prev[c] = din[c];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_valid", int'(ev_valid), int'(m_valid));
      check("model_overflow", int'(overflow), int'(m_ovf));
      if (m_valid) begin
        check("model_ch", int'(ev_ch), m_ch);
        check("model_rise", int'(ev_rise), int'(m_erise));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) tick();
    check("rst_valid", int'(ev_valid), 0);
    check("rst_ch", int'(ev_ch), 0);
    check("rst_rise", int'(ev_rise), 0);
    check("rst_overflow", int'(overflow), 0);
    reset_n = 1'b1;

    // Single rising edge on ch2: two-cycle latency, one-cycle presentation.
    din = 4'b0100;
    tick(); check("t1_latency", int'(ev_valid), 0);
    tick(); check("t1_valid", int'(ev_valid), 1);
    check("t1_ch", int'(ev_ch), 2); check("t1_rise", int'(ev_rise), 1);
    tick(); check("t1_drop", int'(ev_valid), 0);
    din = 4'b0000;
    repeat (4) tick();

    // All four channels rise together: back-to-back events 0..3.
    do_reset();
    din = 4'b1111;
    tick(); check("t2_latency", int'(ev_valid), 0);
    for (int c = 0; c < N; c++) begin
      tick();
      check("t2_ch", int'(ev_ch), c);
      check("t2_rise", int'(ev_rise), 1);
    end
    check("t2_overflow", int'(overflow), 0);
    tick(); check("t2_idle", int'(ev_valid), 0);
    din = 4'b0000;
    repeat (6) tick();

    // After a grant to ch1, pending ch0 and ch3 go 3 then 0.
    din = 4'b0010;
    tick();
    din = 4'b1011;
    tick(); check("t3_first", int'(ev_ch), 1);
    tick(); check("t3_second", int'(ev_ch), 3);
    tick(); check("t3_wrap", int'(ev_ch), 0);
    din = 4'b0000;
    repeat (6) tick();

    // Back-pressure on ch0: held event, retained fall, overflow on the third edge.
    ev_ready = 1'b0;
    din = 4'b0001;
    tick();
    tick(); check("t4_valid", int'(ev_valid), 1);
    check("t4_ch", int'(ev_ch), 0); check("t4_rise", int'(ev_rise), 1);
    din = 4'b0000;
    tick(); check("t4_hold_ch", int'(ev_ch), 0); check("t4_hold_rise", int'(ev_rise), 1);
    din = 4'b0001;
    tick(); check("t4_overflow", int'(overflow), 1);
    check("t4_hold2_rise", int'(ev_rise), 1);
    tick(); check("t4_hold3_valid", int'(ev_valid), 1);
    clear_overflow = 1'b1;
    tick(); check("t4_cleared", int'(overflow), 0);
    clear_overflow = 1'b0;
    ev_ready = 1'b1;
    tick(); check("t4_fall_ch", int'(ev_ch), 0); check("t4_fall_rise", int'(ev_rise), 0);
    tick(); check("t4_idle", int'(ev_valid), 0);
    din = 4'b0000;
    repeat (4) tick();

    // Edge on ch1 in the same cycle its pending rise is granted.
    din = 4'b0010;
    tick();
    din = 4'b0000;
    tick(); check("t5_ch", int'(ev_ch), 1); check("t5_rise", int'(ev_rise), 1);
    tick(); check("t5_ch2", int'(ev_ch), 1); check("t5_rise2", int'(ev_rise), 0);
    check("t5_no_ovf", int'(overflow[1]), 0);
    tick(); check("t5_idle", int'(ev_valid), 0);

    // Asynchronous reset while presenting with three more events pending.
    ev_ready = 1'b0;
    din = 4'b0111;
    tick();
    tick(); check("t6_ch", int'(ev_ch), 2);
    din = 4'b1111;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_valid", int'(ev_valid), 0);
    check("t6_async_ch", int'(ev_ch), 0);
    check("t6_async_rise", int'(ev_rise), 0);
    check("t6_async_ovf", int'(overflow), 0);
    din = 4'b0000;
    ev_ready = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (5) begin
      tick(); check("t6_no_stale", int'(ev_valid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
